// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit constants and special-value codes for encoder/decoder
package posit_pkg;

  localparam int POSIT_WIDTH   = 8;
  localparam int POSIT_EXP     = 2;
  localparam int POSIT_FRAC_IN = 8;
  localparam int POSIT_SCW     = 7;

  // longest regime run (k = WIDTH-2 gives WIDTH-1 ones plus terminator)
  localparam int REGI     = POSIT_WIDTH;
  localparam int MTS      = REGI + POSIT_EXP + POSIT_FRAC_IN;
  localparam int MAXSCALE = (POSIT_WIDTH - 2) << POSIT_EXP;
  localparam int MINSCALE = -MAXSCALE;

  localparam logic [1:0] SPC_ZERO  = 2'b00;
  localparam logic [1:0] SPC_VALID = 2'b01;
  localparam logic [1:0] SPC_NAR   = 2'b10;

endpackage

// File: rtl/posit_encoder_if.sv
// rtl/posit_encoder_if.sv - input/output handshake bundle of the posit encoder
interface posit_encoder_if
  import posit_pkg::*;
#(
  parameter int WIDTH   = POSIT_WIDTH,
  parameter int FRAC_IN = POSIT_FRAC_IN,
  parameter int SCW     = POSIT_SCW
);

  logic                      in_vld_i;
  logic                      in_rdy_o;
  logic                      sign_i;
  logic signed [SCW-1:0]     scale_i;
  logic        [FRAC_IN-1:0] frac_i;
  logic        [1:0]         special_i;
  logic                      out_vld_o;
  logic                      out_rdy_i;
  logic        [WIDTH-1:0]   posit_o;

  modport slave (
    input  in_vld_i, sign_i, scale_i, frac_i, special_i, out_rdy_i,
    output in_rdy_o, out_vld_o, posit_o
  );

  modport master (
    output in_vld_i, sign_i, scale_i, frac_i, special_i, out_rdy_i,
    input  in_rdy_o, out_vld_o, posit_o
  );

endinterface

// File: rtl/posit_regime_pack.sv
// rtl/posit_regime_pack.sv - clamps scale and left-aligns {regime, exponent, fraction}
module posit_regime_pack
  import posit_pkg::*;
#(
  parameter int EXP     = POSIT_EXP,
  parameter int FRAC_IN = POSIT_FRAC_IN,
  parameter int SCW     = POSIT_SCW,
  parameter int RLEN    = REGI,
  parameter int SL      = MTS,
  parameter int MAXS    = MAXSCALE,
  parameter int MINS    = MINSCALE
) (
  input  logic signed [SCW-1:0]     scale_i,
  input  logic        [FRAC_IN-1:0] frac_i,
  output logic        [SL-1:0]      str_o,
  output logic                      sat_hi_o,
  output logic                      sat_lo_o
);

  localparam logic signed [SCW-1:0] SMAX = SCW'(MAXS);
  localparam logic signed [SCW-1:0] SMIN = SCW'(MINS);

  logic signed [SCW-1:0] sc;
  logic signed [SCW-1:0] k;
  logic        [EXP-1:0] e;
  logic        [SL-1:0]  body;
  int                    kk;

  always_comb begin
    sat_hi_o = (scale_i > SMAX);
    sat_lo_o = (scale_i < SMIN);
    sc       = sat_hi_o ? SMAX : (sat_lo_o ? SMIN : scale_i);
    k        = sc >>> EXP;
    e        = sc[EXP-1:0];
    kk       = int'(k);
    // exponent+fraction parked at the top; shifted right past the regime run
    body     = {e, frac_i, {RLEN{1'b0}}};
    if (kk >= 0) begin
      str_o = ~({SL{1'b1}} >> (kk + 1)) | (body >> (kk + 2));
    end else begin
      str_o = ({1'b1, {(SL-1){1'b0}}} >> (-kk)) | (body >> (1 - kk));
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - 2-stage posit packer with rounding/saturation; POSIT_ENC_RNE_EN selects RNE over truncation
module posit_encoder
  import posit_pkg::*;
#(
  parameter int WIDTH   = POSIT_WIDTH,
  parameter int EXP     = POSIT_EXP,
  parameter int FRAC_IN = POSIT_FRAC_IN,
  parameter int SCW     = POSIT_SCW
) (
  input  logic            clk_i,
  input  logic            rstn,
  posit_encoder_if.slave  bus
);

  localparam int SL   = WIDTH + EXP + FRAC_IN;
  localparam int MAXS = (WIDTH - 2) << EXP;
`ifdef POSIT_ENC_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  logic          s1_vld, s1_sign, s1_sat_hi, s1_sat_lo;
  logic [1:0]    s1_spc;
  logic [SL-1:0] s1_str;
  logic             s2_vld;
  logic [WIDTH-1:0] s2_posit;

  logic          adv2, in_rdy;
  logic [SL-1:0] pk_str;
  logic          pk_hi, pk_lo;

  logic [WIDTH-2:0] mag_t, mag;
  logic             guard, sticky, up;
  logic [WIDTH-1:0] mag_r, enc;

  posit_regime_pack #(
    .EXP(EXP), .FRAC_IN(FRAC_IN), .SCW(SCW), .RLEN(WIDTH), .SL(SL),
    .MAXS(MAXS), .MINS(-MAXS)
  ) u_pack (
    .scale_i (bus.scale_i),
    .frac_i  (bus.frac_i),
    .str_o   (pk_str),
    .sat_hi_o(pk_hi),
    .sat_lo_o(pk_lo)
  );

  assign adv2          = ~s2_vld | bus.out_rdy_i;
  assign in_rdy        = ~s1_vld | adv2;
  assign bus.in_rdy_o  = in_rdy;
  assign bus.out_vld_o = s2_vld;
  assign bus.posit_o   = s2_posit;

  always_comb begin
    mag_t  = s1_str[SL-1 -: WIDTH-1];
    guard  = s1_str[SL-WIDTH];
    sticky = |s1_str[SL-WIDTH-1:0];
    up     = RNE_EN & guard & (sticky | mag_t[0]);
    mag_r  = {1'b0, mag_t} + {{(WIDTH-1){1'b0}}, up};
    // a finite value never collapses to zero nor carries past maxpos
    if (s1_sat_hi || mag_r[WIDTH-1]) begin
      mag = '1;
    end else if (s1_sat_lo || (mag_r[WIDTH-2:0] == '0)) begin
      mag = {{(WIDTH-2){1'b0}}, 1'b1};
    end else begin
      mag = mag_r[WIDTH-2:0];
    end
    case (s1_spc)
      SPC_ZERO:  enc = '0;
      SPC_VALID: enc = s1_sign ? (~{1'b0, mag} + WIDTH'(1)) : {1'b0, mag};
      default:   enc = {1'b1, {(WIDTH-1){1'b0}}};
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_spc    <= SPC_ZERO;
      s1_str    <= '0;
      s2_vld    <= 1'b0;
      s2_posit  <= '0;
    end else begin
      if (in_rdy) begin
        s1_vld <= bus.in_vld_i;
        if (bus.in_vld_i) begin
          s1_sign   <= bus.sign_i;
          s1_sat_hi <= pk_hi;
          s1_sat_lo <= pk_lo;
          s1_spc    <= bus.special_i;
          s1_str    <= pk_str;
        end
      end
      if (adv2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_posit <= enc;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// tb/tb_posit_encoder.sv - directed vector bench for posit_encoder (8-bit, es=2)
module tb_posit_encoder;

  typedef struct {
    logic              sign;
    logic signed [6:0] scale;
    logic [7:0]        frac;
    logic [1:0]        spc;
    logic [7:0]        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   nvec = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  posit_encoder_if #(.WIDTH(8), .FRAC_IN(8), .SCW(7)) bus ();

  posit_encoder #(.WIDTH(8), .EXP(2), .FRAC_IN(8), .SCW(7)) dut (
    .clk_i(clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input int sc, input logic [7:0] f,
                              input logic [1:0] sp, input logic [7:0] e);
    vec_t v;
    v.sign  = s;
    v.scale = 7'(sc);
    v.frac  = f;
    v.spc   = sp;
    v.exp   = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.sign_i    = v.sign;
    bus.scale_i   = v.scale;
    bus.frac_i    = v.frac;
    bus.special_i = v.spc;
    bus.in_vld_i  = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, output logic [7:0] got, output int edges);
    int t;
    @(negedge clk);
    drive(v);
    #1;
    t = 0;
    while (!bus.in_rdy_o && t < 20) begin
      @(negedge clk); #1; t++;
    end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.in_vld_i = 1'b0;
    #1;
    while (!bus.out_vld_o && edges < 20) begin
      @(negedge clk); #1; edges++;
    end
    got = bus.posit_o;
  endtask

  vec_t       vt[$];
  vec_t       beats[4];
  logic [7:0] exp_beats[4];
  logic [7:0] got_q[$];

  initial begin
    logic [7:0] got;
    int         edges;
    logic       saw_low;
    logic       seen;

    bus.in_vld_i  = 1'b0;
    bus.sign_i    = 1'b0;
    bus.scale_i   = '0;
    bus.frac_i    = '0;
    bus.special_i = 2'b00;
    bus.out_rdy_i = 1'b1;

    vt.push_back(mk(0,   0, 8'h00, 2'b01, 8'h40));
    vt.push_back(mk(1,   0, 8'h00, 2'b01, 8'hC0));
    vt.push_back(mk(0,   0, 8'h80, 2'b01, 8'h44));
    vt.push_back(mk(0,   0, 8'h90, 2'b01, 8'h44));
`ifdef POSIT_ENC_RNE_EN
    vt.push_back(mk(0,   0, 8'hB0, 2'b01, 8'h46));
    vt.push_back(mk(0,   0, 8'h98, 2'b01, 8'h45));
    vt.push_back(mk(0,  23, 8'h00, 2'b01, 8'h7F));
    vt.push_back(mk(0, -21, 8'h00, 2'b01, 8'h02));
`else
    vt.push_back(mk(0,   0, 8'hB0, 2'b01, 8'h45));
    vt.push_back(mk(0,   0, 8'h98, 2'b01, 8'h44));
    vt.push_back(mk(0,  23, 8'h00, 2'b01, 8'h7E));
    vt.push_back(mk(0, -21, 8'h00, 2'b01, 8'h01));
`endif
    vt.push_back(mk(0,  24, 8'h00, 2'b01, 8'h7F));
    vt.push_back(mk(0,  30, 8'h00, 2'b01, 8'h7F));
    vt.push_back(mk(0, -24, 8'h00, 2'b01, 8'h01));
    vt.push_back(mk(0, -30, 8'h00, 2'b01, 8'h01));
    vt.push_back(mk(1,  30, 8'h00, 2'b01, 8'h81));
    vt.push_back(mk(1, -30, 8'h00, 2'b01, 8'hFF));
    vt.push_back(mk(0,   5, 8'h55, 2'b00, 8'h00));
    vt.push_back(mk(1,   5, 8'h55, 2'b10, 8'h80));
    vt.push_back(mk(0,   5, 8'h55, 2'b11, 8'h80));
    vt.push_back(mk(0,  -1, 8'h00, 2'b01, 8'h38));
    vt.push_back(mk(0,   5, 8'h40, 2'b01, 8'h65));
    vt.push_back(mk(1,   5, 8'h40, 2'b01, 8'h9B));
    vt.push_back(mk(0,  20, 8'hFF, 2'b01, 8'h7E));

    // reset state
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("rst_out_vld", {31'b0, bus.out_vld_o}, 32'd0);
    chk("rst_posit",   {24'b0, bus.posit_o},   32'd0);
    chk("rst_in_rdy",  {31'b0, bus.in_rdy_o},  32'd1);

    foreach (vt[i]) begin
      run_vec(vt[i], got, edges);
      chk($sformatf("vec%0d_posit", i), {24'b0, got}, {24'b0, vt[i].exp});
      chk($sformatf("vec%0d_latency", i), 32'(edges), 32'd2);
    end

    // four back-to-back beats with a 3-cycle downstream stall
    beats[0] = mk(0,  0, 8'h00, 2'b01, 8'h40);
    beats[1] = mk(0, -1, 8'h00, 2'b01, 8'h38);
    beats[2] = mk(0,  5, 8'h40, 2'b01, 8'h65);
    beats[3] = mk(0, 24, 8'h00, 2'b01, 8'h7F);
    foreach (beats[i]) exp_beats[i] = beats[i].exp;
    saw_low = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int t;
          @(negedge clk);
          drive(beats[i]);
          #1;
          t = 0;
          while (!bus.in_rdy_o && t < 20) begin
            @(negedge clk); #1; t++;
          end
          @(posedge clk);
        end
        @(negedge clk);
        bus.in_vld_i = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        bus.out_rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_rdy_i = 1'b1;
      end
      begin
        logic       pv, pr;
        logic [7:0] pp;
        pv = 1'b0; pr = 1'b1; pp = '0;
        repeat (30) begin
          @(negedge clk); #2;
          if (pv && !pr) begin
            chk("stall_hold_vld",  {31'b0, bus.out_vld_o}, 32'd1);
            chk("stall_hold_data", {24'b0, bus.posit_o},   {24'b0, pp});
          end
          if (!bus.in_rdy_o) saw_low = 1'b1;
          if (bus.out_vld_o && bus.out_rdy_i) got_q.push_back(bus.posit_o);
          pv = bus.out_vld_o;
          pr = bus.out_rdy_i;
          pp = bus.posit_o;
        end
      end
    join
    chk("stall_in_rdy_dropped", {31'b0, saw_low}, 32'd1);
    chk("stall_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 8'hxx;
      chk($sformatf("stall_beat%0d", i), {24'b0, got}, {24'b0, exp_beats[i]});
    end

    // reset with both stages full
    @(negedge clk);
    bus.out_rdy_i = 1'b0;
    drive(beats[2]);
    @(posedge clk);
    @(negedge clk);
    drive(beats[3]);
    @(posedge clk);
    @(negedge clk);
    bus.in_vld_i = 1'b0;
    #1;
    chk("full_in_rdy",  {31'b0, bus.in_rdy_o},  32'd0);
    chk("full_out_vld", {31'b0, bus.out_vld_o}, 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_vld", {31'b0, bus.out_vld_o}, 32'd0);
    chk("midrst_posit",   {24'b0, bus.posit_o},   32'd0);
    chk("midrst_in_rdy",  {31'b0, bus.in_rdy_o},  32'd1);
    @(negedge clk);
    rstn = 1'b1;
    bus.out_rdy_i = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk); #2;
      if (bus.out_vld_o) seen = 1'b1;
    end
    chk("postrst_no_output", {31'b0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
